// File: rtl/up_sample_2x.sv
// Nearest-neighbour 2x upscaler on AXI4-Stream: every pixel is emitted twice,
// and every line is replayed once more from an internal line buffer.
module up_sample_2x #(
   parameter int WIDTH       = 24,
   parameter int TUSER_WIDTH = 1,
   parameter int MAX_IN_COLS = 640,
   parameter int CNT_W       = 16
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   input  logic [WIDTH-1:0]       s_axis_tdata,
   input  logic                   s_axis_tlast,
   input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [WIDTH-1:0]       m_axis_tdata,
   output logic                   m_axis_tlast,
   output logic [TUSER_WIDTH-1:0] m_axis_tuser,
   output logic                   err_ovf
);

   localparam int AW = (MAX_IN_COLS > 1) ? $clog2(MAX_IN_COLS) : 1;
   localparam logic [CNT_W:0]   MAX_EXT = (CNT_W+1)'(MAX_IN_COLS);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {PASS = 1'b0, REPEAT = 1'b1} state_t;

   state_t                   state_q, state_d;
   logic                     phase_q, phase_d;
   logic                     last_q, last_d;
   logic [CNT_W-1:0]         wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0]         rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0]         len_q, len_d;
   logic                     tvalid_q, tvalid_d;
   logic [WIDTH-1:0]         tdata_q, tdata_d;
   logic                     tlast_q, tlast_d;
   logic [TUSER_WIDTH-1:0]   tuser_q, tuser_d;
   logic                     err_q, err_d;

   logic [WIDTH-1:0]         line_buf [MAX_IN_COLS];
   logic [WIDTH-1:0]         buf_rd;
   logic                     buf_we;
   logic [CNT_W:0]           wr_inc;
   logic                     store;
   logic                     rd_last;
   logic                     adv;
   logic                     s_ready;
   logic                     accept;

   // The output register may be (re)loaded whenever it is empty or being drained.
   assign adv     = !tvalid_q || m_axis_tready;
   assign s_ready = aresetn && (state_q == PASS) && !phase_q && adv;
   assign accept  = s_axis_tvalid && s_ready;
   assign wr_inc  = {1'b0, wr_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
   assign store   = ({1'b0, wr_cnt_q} < MAX_EXT);
   assign rd_last = ((rd_cnt_q + CNT_ONE) == len_q);
   assign buf_rd  = line_buf[rd_cnt_q[AW-1:0]];

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      last_d   = last_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      len_d    = len_q;
      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      tlast_d  = tlast_q;
      tuser_d  = tuser_q;
      err_d    = err_q;
      buf_we   = 1'b0;

      case (state_q)
         PASS: begin
            if (!phase_q) begin
               if (accept) begin
                  tvalid_d = 1'b1;
                  tdata_d  = s_axis_tdata;
                  tuser_d  = s_axis_tuser;
                  tlast_d  = 1'b0;
                  last_d   = s_axis_tlast;
                  phase_d  = 1'b1;
                  if (store) begin
                     buf_we = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (adv) begin
                  tvalid_d = 1'b0;
               end
            end else if (adv) begin
               // Second horizontal copy reuses the data already in the output register.
               tvalid_d = 1'b1;
               tuser_d  = '0;
               tlast_d  = last_q;
               phase_d  = 1'b0;
               if (last_q) begin
                  len_d    = (wr_inc > MAX_EXT) ? MAX_EXT[CNT_W-1:0] : wr_inc[CNT_W-1:0];
                  wr_cnt_d = '0;
                  state_d  = REPEAT;
               end else if (wr_cnt_q != CNT_MAX) begin
                  wr_cnt_d = wr_cnt_q + CNT_ONE;
               end
            end
         end
         REPEAT: begin
            if (adv) begin
               tvalid_d = 1'b1;
               tdata_d  = buf_rd;
               tuser_d  = '0;
               tlast_d  = phase_q && rd_last;
               phase_d  = !phase_q;
               if (phase_q) begin
                  if (rd_last) begin
                     rd_cnt_d = '0;
                     state_d  = PASS;
                  end else begin
                     rd_cnt_d = rd_cnt_q + CNT_ONE;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= PASS;
         phase_q  <= 1'b0;
         last_q   <= 1'b0;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         len_q    <= '0;
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         tlast_q  <= 1'b0;
         tuser_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         last_q   <= last_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
         len_q    <= len_d;
         tvalid_q <= tvalid_d;
         tdata_q  <= tdata_d;
         tlast_q  <= tlast_d;
         tuser_q  <= tuser_d;
         err_q    <= err_d;
      end
   end

   // Line buffer contents carry no reset.
   always_ff @(posedge aclk) begin
      if (buf_we) begin
         line_buf[wr_cnt_q[AW-1:0]] <= s_axis_tdata;
      end
   end

   assign s_axis_tready = s_ready;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tuser  = tuser_q;
   assign err_ovf       = err_q;

endmodule

// File: tb/tb_up_sample_2x.sv
// Scoreboard bench for up_sample_2x: each line's expected beats are derived from
// the upscaling rules and queued; a monitor checks every output handshake.
module tb_up_sample_2x;

   localparam int W   = 24;
   localparam int TU  = 1;
   localparam int MAX = 8;
   localparam int CW  = 16;

   logic          clk = 1'b0;
   logic          aresetn = 1'b0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic [W-1:0]  s_axis_tdata = '0;
   logic          s_axis_tlast = 1'b0;
   logic [TU-1:0] s_axis_tuser = '0;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic [W-1:0]  m_axis_tdata;
   logic          m_axis_tlast;
   logic [TU-1:0] m_axis_tuser;
   logic          err_ovf;

   typedef struct packed {
      logic [W-1:0] d;
      logic         l;
      logic         u;
   } beat_t;

   beat_t        exp_q[$];
   int           checks = 0;
   int           errors = 0;
   bit           exp_err = 1'b0;
   int           tready_mode = 0;
   int           last_run = 0;
   logic [W-1:0] line_pix [0:31];

   always #5 clk = ~clk;

   up_sample_2x #(
      .WIDTH(W), .TUSER_WIDTH(TU), .MAX_IN_COLS(MAX), .CNT_W(CW)
   ) dut (
      .aclk(clk),
      .aresetn(aresetn),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .s_axis_tdata(s_axis_tdata),
      .s_axis_tlast(s_axis_tlast),
      .s_axis_tuser(s_axis_tuser),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata),
      .m_axis_tlast(m_axis_tlast),
      .m_axis_tuser(m_axis_tuser),
      .err_ovf(err_ovf)
   );

   // Downstream ready: 0 = always high, 1 = toggling, 2 = random.
   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (tready_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin : monitor
      bit    stalled;
      beat_t held;
      beat_t got;
      beat_t want;
      int    run;
      stalled = 1'b0;
      run = 0;
      forever begin
         @(negedge clk);
         if (!aresetn) begin
            stalled = 1'b0;
            run = 0;
         end else begin
            got = {m_axis_tdata, m_axis_tlast, m_axis_tuser[0]};
            if (stalled) begin
               checks++;
               if (!m_axis_tvalid || got != held) begin
                  errors++;
                  $display("FAIL stall_hold: got valid=%0b data=%h last=%0b user=%0b, required valid=1 data=%h last=%0b user=%0b",
                           m_axis_tvalid, got.d, got.l, got.u, held.d, held.l, held.u);
               end
            end
            if (m_axis_tvalid) begin
               run++;
            end else begin
               if (run > 0) last_run = run;
               run = 0;
            end
            if (m_axis_tvalid && m_axis_tready) begin
               stalled = 1'b0;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_beat: got data=%h last=%0b user=%0b, required no beat",
                           got.d, got.l, got.u);
               end else begin
                  want = exp_q.pop_front();
                  if (got != want) begin
                     errors++;
                     $display("FAIL beat: got data=%h last=%0b user=%0b, required data=%h last=%0b user=%0b",
                              got.d, got.l, got.u, want.d, want.l, want.u);
                  end else begin
                     $display("beat data=%h last=%0b user=%0b ok", got.d, got.l, got.u);
                  end
               end
            end else if (m_axis_tvalid) begin
               stalled = 1'b1;
               held = got;
            end else begin
               stalled = 1'b0;
            end
         end
      end
   end

   task automatic check_bit(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0b, required %0b", name, act, req);
      end
   endtask

   task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic drive_beat(input logic [W-1:0] d, input logic u, input logic l, output int waits);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tuser  = TU'(u);
      s_axis_tlast  = l;
      waits = 0;
      while (1) begin
         @(negedge clk);
         waits++;
         if (s_axis_tready) break;
         if (waits >= 1000) begin
            errors++;
            $display("FAIL accept_timeout: got no s_axis_tready in %0d cycles, required acceptance", waits);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1, "input never accepted");
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Reference model: each pixel twice with tuser on copy 0 and tlast on the final
   // copy, then the first min(n,MAX) pixels twice again with tlast on the last beat.
   task automatic send_line(input int n, input bit sof, input int gap_max, input bit thru);
      int nrep;
      int waits;
      int g;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({line_pix[i], 1'b0, (sof && i == 0)});
         exp_q.push_back({line_pix[i], (i == n - 1), 1'b0});
      end
      nrep = (n < MAX) ? n : MAX;
      for (int j = 0; j < nrep; j++) begin
         exp_q.push_back({line_pix[j], 1'b0, 1'b0});
         exp_q.push_back({line_pix[j], (j == nrep - 1), 1'b0});
      end
      for (int i = 0; i < n; i++) begin
         drive_beat(line_pix[i], (sof && i == 0), (i == n - 1), waits);
         if (thru) begin
            checks++;
            if (waits != ((i == 0) ? 1 : 2)) begin
               errors++;
               $display("FAIL s_ready_pattern: got %0d cycles to accept pixel %0d, required %0d",
                        waits, i, (i == 0) ? 1 : 2);
            end
         end
         if (i >= MAX) exp_err = 1'b1;
         check_bit("err_ovf", err_ovf, exp_err);
         if (!thru && gap_max > 0) begin
            g = $urandom_range(0, gap_max);
            if (g > 0) begin
               s_axis_tvalid = 1'b0;
               repeat (g) begin
                  @(posedge clk);
                  #1;
               end
            end
         end
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = '0;
   endtask

   task automatic wait_drain();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 5000) begin
         @(posedge clk);
         g++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d beats outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic send_frame_1_to_8(input int gap_max);
      for (int i = 0; i < 4; i++) line_pix[i] = W'(i + 1);
      send_line(4, 1'b1, gap_max, 1'b0);
      for (int i = 0; i < 4; i++) line_pix[i] = W'(i + 5);
      send_line(4, 1'b0, gap_max, 1'b0);
      wait_drain();
   endtask

   initial begin
      #3000000;
      errors++;
      $display("FAIL watchdog: got simulation time limit, required completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : stimulus
      int g;
      int n;

      // Reset state
      #12;
      check_bit("rst_m_tvalid", m_axis_tvalid, 1'b0);
      check_vec("rst_m_tdata", m_axis_tdata, '0);
      check_bit("rst_m_tlast", m_axis_tlast, 1'b0);
      check_bit("rst_m_tuser", m_axis_tuser[0], 1'b0);
      check_bit("rst_err_ovf", err_ovf, 1'b0);
      check_bit("rst_s_tready", s_axis_tready, 1'b0);
      @(negedge clk);
      aresetn = 1'b1;
      @(posedge clk);
      #1;

      // 4x2 frame, ready high, then with ready toggling
      tready_mode = 0;
      send_frame_1_to_8(0);
      tready_mode = 1;
      send_frame_1_to_8(0);
      tready_mode = 0;

      // Single-pixel lines
      line_pix[0] = W'(24'hA);
      send_line(1, 1'b1, 0, 1'b0);
      line_pix[0] = W'(24'hB);
      send_line(1, 1'b0, 0, 1'b0);
      wait_drain();

      // Overflow: line of MAX+2 pixels
      for (int i = 0; i < MAX + 2; i++) line_pix[i] = W'(i + 1);
      send_line(MAX + 2, 1'b1, 0, 1'b0);
      wait_drain();
      check_bit("err_ovf_sticky", err_ovf, 1'b1);

      // Async reset while REPEAT is replaying
      for (int i = 0; i < MAX + 2; i++) line_pix[i] = W'(24'h100 + i);
      send_line(MAX + 2, 1'b1, 0, 1'b0);
      g = 0;
      while (exp_q.size() > 2 * MAX - 4 && g < 500) begin
         @(posedge clk);
         g++;
      end
      checks++;
      if (exp_q.size() > 2 * MAX - 4) begin
         errors++;
         $display("FAIL repeat_reach: got %0d beats outstanding, required <= %0d", exp_q.size(), 2 * MAX - 4);
      end
      #3;
      aresetn = 1'b0;
      #1;
      check_bit("arst_m_tvalid", m_axis_tvalid, 1'b0);
      check_vec("arst_m_tdata", m_axis_tdata, '0);
      check_bit("arst_m_tlast", m_axis_tlast, 1'b0);
      check_bit("arst_m_tuser", m_axis_tuser[0], 1'b0);
      check_bit("arst_err_ovf", err_ovf, 1'b0);
      check_bit("arst_s_tready", s_axis_tready, 1'b0);
      exp_q.delete();
      exp_err = 1'b0;
      @(negedge clk);
      @(negedge clk);
      aresetn = 1'b1;
      @(posedge clk);
      #1;
      line_pix[0] = W'(10);
      line_pix[1] = W'(20);
      send_line(2, 1'b1, 0, 1'b0);
      wait_drain();

      // Throughput: continuous input, 8-pixel line
      tready_mode = 0;
      for (int i = 0; i < 8; i++) line_pix[i] = W'(24'h200 + i);
      send_line(8, 1'b1, 0, 1'b1);
      wait_drain();
      checks++;
      if (last_run != 32) begin
         errors++;
         $display("FAIL valid_run: got %0d consecutive valid cycles, required 32", last_run);
      end

      // Randomized frames with random downstream backpressure and input gaps
      tready_mode = 2;
      for (int f = 0; f < 3; f++) begin
         for (int l = 0; l < 3; l++) begin
            n = $urandom_range(1, MAX + 4);
            for (int i = 0; i < n; i++) line_pix[i] = W'($urandom);
            send_line(n, (l == 0), 2, 1'b0);
         end
      end
      wait_drain();
      check_bit("err_ovf_final", err_ovf, exp_err);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/up_sample_2x.md
# up_sample_2x

Nearest-neighbour 2x video upscaler on AXI4-Stream. Each input pixel is emitted twice horizontally, and each input line is emitted twice vertically; the repeated line is replayed from an internal line buffer. It sits directly downstream of the 2:1 down-sampler and restores the original raster size for display or loop-back checking in the video simulation chain.

## Interface
- `WIDTH`, 24: pixel data width.
- `TUSER_WIDTH`, 1: tuser width; bit 0 is SOF.
- `MAX_IN_COLS`, 640: line buffer depth, i.e. the maximum input line length.
- `CNT_W`, 16: width of the column and length counters.
- `aclk` in 1: clock; one clock domain only.
- `aresetn` in 1: reset, asynchronous, active-low.
- `s_axis_tvalid` in 1: input beat valid.
- `s_axis_tready` out 1: input beat accepted when high together with tvalid.
- `s_axis_tdata` in WIDTH: input pixel.
- `s_axis_tlast` in 1: last pixel of input line.
- `s_axis_tuser` in TUSER_WIDTH: bit 0 marks first pixel of frame.
- `m_axis_tvalid` out 1: output beat valid, registered.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tdata` out WIDTH: output pixel, registered.
- `m_axis_tlast` out 1: last pixel of output line, registered.
- `m_axis_tuser` out TUSER_WIDTH: SOF, registered.
- `err_ovf` out 1: sticky flag, input line longer than MAX_IN_COLS.

## Operation
- States are PASS (reset state) and REPEAT.
- PASS, copy phase 0:
  - `s_axis_tready = (state==PASS) && !phase && (!m_axis_tvalid || m_axis_tready)`.
  - On accept: load the output register with data, `tuser = s_axis_tuser`, `tlast = 0`.
  - Write the pixel to `buf[wr_cnt]` if `wr_cnt < MAX_IN_COLS`.
  - Latch `s_axis_tlast` into `last_q` and set phase to 1.
- PASS, copy phase 1:
  - On output handshake, reload the same data with `tuser = 0` and `tlast = last_q`; phase returns to 0.
  - If `last_q` is set: `len <= min(wr_cnt+1, MAX_IN_COLS)`, clear `wr_cnt`, go to REPEAT. Otherwise increment `wr_cnt`.
- REPEAT:
  - No input is accepted (`s_axis_tready = 0`).
  - Emit `buf[rd_cnt]` twice per address for `rd_cnt = 0..len-1`.
  - `tuser = 0` on every beat; `tlast` on the second copy of `rd_cnt = len-1`.
  - After that beat is loaded, clear `rd_cnt` and return to PASS.
- Line buffer: reg array, `MAX_IN_COLS × WIDTH`, combinational read. Contents are not reset.
- Overflow: input pixels at `wr_cnt >= MAX_IN_COLS` are still duplicated horizontally in PASS but are not stored. `err_ovf` is set and stays set until reset. REPEAT replays only `MAX_IN_COLS` pixels.
- SOF mid-line: no resynchronisation. tuser[0] is forwarded on copy 0 only, and the counters continue.
- A single-pixel line (tlast on the first beat) is legal: it produces 2 beats in PASS and 2 beats in REPEAT.
- Counters: `wr_cnt`, `rd_cnt` and `len` are CNT_W bits wide. `wr_cnt` saturates at `2^CNT_W-1` and never wraps.

## Timing
- Reset (async assert) values: `m_axis_tvalid=0`, `m_axis_tdata=0`, `m_axis_tlast=0`, `m_axis_tuser=0`, `err_ovf=0`, `s_axis_tready=0` while aresetn is low. State returns to PASS, and phase, `wr_cnt`, `rd_cnt` and `len` are all 0.
- Reset mid-line or mid-REPEAT: the partial output line is abandoned; the next accepted input starts a new line at column 0.
- Latency: an input accepted at edge k makes `m_axis_tvalid` high after edge k; copy 1 follows on the next handshake edge.
- Throughput:
  - PASS accepts at most 1 input per 2 cycles and produces 1 output beat per cycle with `m_axis_tready` held high.
  - REPEAT takes 2·len cycles with no bubbles.
  - The PASS→REPEAT and REPEAT→PASS transitions add no idle cycles on the output.
- AXIS rules:
  - `m_axis_tdata`, `tlast` and `tuser` stay stable while `m_axis_tvalid && !m_axis_tready`.
  - `m_axis_tvalid` never drops without a handshake.
  - `s_axis_tready` does not depend combinationally on `s_axis_tvalid`.

## Test plan
- **4×2 frame**, data 1..8, SOF on 1, tlast on 4 and 8, `m_axis_tready=1`:
  - Output rows: 1,1,2,2,3,3,4,4 twice, then 5,5,6,6,7,7,8,8 twice.
  - tlast on every 8th beat; tuser only on the first beat.
- **Same frame, `m_axis_tready` toggling 1,0,1,0**: identical beat sequence, with data, tlast and tuser held stable on every stall cycle.
- **Single-pixel lines**, 0xA (SOF+tlast) then 0xB (tlast):
  - Beats: A(tuser), A(tlast), A, A(tlast), B, B(tlast), B, B(tlast).
- **Overflow**, `MAX_IN_COLS=4`, 6-pixel line 1..6:
  - PASS emits 12 beats 1,1..6,6.
  - REPEAT emits 8 beats 1,1..4,4 with tlast on the last.
  - `err_ovf=1` after pixel 5 is accepted and remains 1.
- **Async reset asserted during REPEAT**:
  - All outputs are 0 with no clock edge needed; `err_ovf` is cleared.
  - After release, line 10,20 produces 10,10,20,20 twice.
- **Throughput**, continuous valid input, `m_axis_tready=1`, 8-pixel line:
  - `s_axis_tready` alternates 1,0.
  - Output is valid on 32 consecutive cycles.
